// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the hazard-case encoding and the register-source match helper.
package hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } fsm_t;

    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_MISS     = 3'd1,
        HZ_CTRL     = 3'd2,
        HZ_LOAD_USE = 3'd3,
        HZ_JAL      = 3'd4
    } hz_case_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a load targeting it can never create a dependency.
    function automatic logic src_hazard(input logic [4:0] rs,
                                        input logic       used,
                                        input logic [4:0] rd);
        return used && (rd != REG_X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module hz_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (inc && (q_reg != MAX_VAL)) begin
            q_next = q_reg + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-segment bubble/flush requests for load-use,
// control-transfer and data-cache-miss hazards, plus perf counters and a miss watchdog.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [4:0]       rd_EX,
    input  logic             load_EX,
    input  logic             br_taken_EX,
    input  logic             jalr_EX,
    input  logic             jal_ID,
    input  logic             dcache_miss,
    input  logic             dcache_done,
    input  logic             cnt_clr,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             miss_timeout
);

    localparam int              MC_W   = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MC_W-1:0] MC_MAX = MC_W'(MISS_TIMEOUT);
    localparam logic [MC_W-1:0] MC_ONE = MC_W'(1);

    fsm_t            state_reg;
    fsm_t            state_next;
    logic [MC_W-1:0] miss_cnt_reg;
    logic [MC_W-1:0] miss_cnt_next;
    logic            miss_timeout_reg;
    logic            miss_timeout_next;

    hz_case_t        hz_case;
    logic            load_use;
    logic [4:0]      bubble_vec;
    logic [4:0]      flush_vec;
    logic            stall_inc;
    logic            flush_inc;

    logic [4:0]      rs_src [2];
    logic [1:0]      used_src;
    logic [1:0]      src_hit;

    assign rs_src[0]   = rs1_ID;
    assign rs_src[1]   = rs2_ID;
    assign used_src[0] = rs1_used;
    assign used_src[1] = rs2_used;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_hazard(rs_src[gi], used_src[gi], rd_EX);
        end
    endgenerate

    assign load_use = load_EX && (|src_hit);

    // While stalled on a miss every other hazard input is ignored.
    always_comb begin
        hz_case = HZ_NONE;
        if ((state_reg == MISS) || dcache_miss) begin
            hz_case = HZ_MISS;
        end else if (br_taken_EX || jalr_EX) begin
            hz_case = HZ_CTRL;
        end else if (load_use) begin
            hz_case = HZ_LOAD_USE;
        end else if (jal_ID) begin
            hz_case = HZ_JAL;
        end
    end

    // Vector bit order is F,D,E,M,W from MSB to LSB.
    always_comb begin
        bubble_vec = 5'b00000;
        flush_vec  = 5'b00000;
        case (hz_case)
            HZ_MISS: begin
                bubble_vec = 5'b11110;
                flush_vec  = 5'b00001;
            end
            HZ_CTRL: begin
                flush_vec  = 5'b01100;
            end
            HZ_LOAD_USE: begin
                bubble_vec = 5'b11000;
                flush_vec  = 5'b00100;
            end
            HZ_JAL: begin
                flush_vec  = 5'b01000;
            end
            default: begin
                bubble_vec = 5'b00000;
                flush_vec  = 5'b00000;
            end
        endcase
        if (rst) begin
            bubble_vec = 5'b00000;
            flush_vec  = 5'b11111;
        end
    end

    assign {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = bubble_vec;
    assign {flushF,  flushD,  flushE,  flushM,  flushW}  = flush_vec;

    always_comb begin
        state_next        = state_reg;
        miss_cnt_next     = miss_cnt_reg;
        miss_timeout_next = miss_timeout_reg;
        case (state_reg)
            RUN: begin
                if (dcache_miss) begin
                    state_next = MISS;
                end
            end
            MISS: begin
                if (miss_cnt_reg != MC_MAX) begin
                    miss_cnt_next = miss_cnt_reg + MC_ONE;
                end
                if (miss_cnt_next == MC_MAX) begin
                    miss_timeout_next = 1'b1;
                end
                if (dcache_done) begin
                    state_next    = RUN;
                    miss_cnt_next = '0;
                end
            end
            default: begin
                state_next    = RUN;
                miss_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= RUN;
            miss_cnt_reg     <= '0;
            miss_timeout_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            miss_cnt_reg     <= miss_cnt_next;
            miss_timeout_reg <= miss_timeout_next;
        end
    end

    assign miss_timeout = miss_timeout_reg;

    assign stall_inc = |bubble_vec;
    assign flush_inc = (hz_case == HZ_CTRL) || (hz_case == HZ_JAL);

    hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (stall_inc),
        .q   (stall_cycles)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (flush_inc),
        .q   (flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MT    = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_ID, rs2_ID, rd_EX;
    logic             rs1_used, rs2_used, load_EX, br_taken_EX, jalr_EX, jal_ID;
    logic             dcache_miss, dcache_done, cnt_clr;
    logic             bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic             flushF, flushD, flushE, flushM, flushW;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic             miss_timeout;
    logic [9:0]       outs;

    int errors = 0;
    int checks = 0;

    // Model state
    bit model_en = 1'b0;
    bit m_miss   = 1'b0;
    int m_len    = 0;
    bit m_to     = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MISS_TIMEOUT(MT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rd_EX        (rd_EX),
        .load_EX      (load_EX),
        .br_taken_EX  (br_taken_EX),
        .jalr_EX      (jalr_EX),
        .jal_ID       (jal_ID),
        .dcache_miss  (dcache_miss),
        .dcache_done  (dcache_done),
        .cnt_clr      (cnt_clr),
        .bubbleF      (bubbleF),
        .bubbleD      (bubbleD),
        .bubbleE      (bubbleE),
        .bubbleM      (bubbleM),
        .bubbleW      (bubbleW),
        .flushF       (flushF),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
        .miss_timeout (miss_timeout)
    );

    assign outs = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                   flushF,  flushD,  flushE,  flushM,  flushW};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input bit verbose);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else if (verbose) begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic idle();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; load_EX = 1'b0;
        br_taken_EX = 1'b0; jalr_EX = 1'b0; jal_ID = 1'b0;
        dcache_miss = 1'b0; dcache_done = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        load_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; rs1_used = 1'b1;
    endtask

    // Which hazard rule applies this cycle: 0 none, 1 miss, 2 control, 3 load-use, 4 jal.
    function automatic int hz_rule();
        bit dep;
        dep = load_EX && (rd_EX != 5'd0) &&
              ((rs1_used && (rs1_ID == rd_EX)) || (rs2_used && (rs2_ID == rd_EX)));
        if (m_miss || dcache_miss) return 1;
        if (br_taken_EX || jalr_EX) return 2;
        if (dep)                    return 3;
        if (jal_ID)                 return 4;
        return 0;
    endfunction

    function automatic logic [9:0] rule_outs(input int r);
        case (r)
            1:       return 10'b11110_00001;
            2:       return 10'b00000_01100;
            3:       return 10'b11000_00100;
            4:       return 10'b00000_01000;
            default: return 10'b00000_00000;
        endcase
    endfunction

    always @(negedge clk) begin
        int r;
        logic [9:0] e;
        if (model_en) begin
            if (rst) begin
                m_miss = 1'b0; m_len = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
                e = 10'b00000_11111;
                r = 0;
            end else begin
                r = hz_rule();
                e = rule_outs(r);
            end
            check("model_outs",    outs,         e,       1'b0);
            check("model_stall",   stall_cycles, m_stall, 1'b0);
            check("model_flush",   flush_events, m_flush, 1'b0);
            check("model_timeout", miss_timeout, m_to,    1'b0);
            if (!rst) begin
                if (cnt_clr)                              m_stall = 0;
                else if ((r == 1 || r == 3) && m_stall < CMAX) m_stall++;
                if (cnt_clr)                              m_flush = 0;
                else if ((r == 2 || r == 4) && m_flush < CMAX) m_flush++;
                if (m_miss) begin
                    m_len++;
                    if (m_len >= MT) m_to = 1'b1;
                    if (dcache_done) begin
                        m_miss = 1'b0;
                        m_len  = 0;
                    end
                end else if (dcache_miss) begin
                    m_miss = 1'b1;
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        model_en = 1'b1;

        @(negedge clk);
        check("reset_outs",    outs,         10'h01F, 1'b1);
        check("reset_stall",   stall_cycles, 0, 1'b1);
        check("reset_flush",   flush_events, 0, 1'b1);
        check("reset_timeout", miss_timeout, 0, 1'b1);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("idle_outs", outs, 10'h000, 1'b1);

        next_cycle(); set_load_use();
        @(negedge clk);
        check("load_use_outs", outs, 10'b11000_00100, 1'b1);
        next_cycle(); idle();
        @(negedge clk);
        check("load_use_one_cycle", outs, 10'h000, 1'b1);
        check("load_use_stall", stall_cycles, 1, 1'b1);

        next_cycle(); load_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; rs1_used = 1'b1;
        @(negedge clk);
        check("x0_no_stall", outs, 10'h000, 1'b1);
        next_cycle(); idle(); load_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7;
        rs1_ID = 5'd3; rs1_used = 1'b1;
        @(negedge clk);
        check("rs2_unused_no_stall", outs, 10'h000, 1'b1);

        next_cycle(); idle(); load_EX = 1'b1; rd_EX = 5'd9; rs2_ID = 5'd9;
        rs2_used = 1'b1; br_taken_EX = 1'b1;
        @(negedge clk);
        check("br_over_load_use", outs, 10'b00000_01100, 1'b1);
        next_cycle(); idle();
        @(negedge clk);
        check("br_flush_events", flush_events, 1, 1'b1);
        check("br_stall_unchanged", stall_cycles, 1, 1'b1);

        // Miss with data back on the fifth MISS cycle; also crosses the timeout.
        next_cycle(); dcache_miss = 1'b1;
        @(negedge clk);
        check("miss_enter_outs", outs, 10'h3C1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            next_cycle(); idle();
            dcache_miss = 1'b1;
            dcache_done = (k == 5);
            br_taken_EX = (k == 2);
            @(negedge clk);
            check($sformatf("miss_hold_outs_%0d", k), outs, 10'h3C1, 1'b1);
            if (k == 4) check("timeout_not_yet", miss_timeout, 0, 1'b1);
            if (k == 5) check("timeout_after_4th", miss_timeout, 1, 1'b1);
        end
        next_cycle(); idle();
        @(negedge clk);
        check("miss_exit_run", outs, 10'h000, 1'b1);
        check("miss_stall_cycles", stall_cycles, 7, 1'b1);
        check("miss_ignored_branch", flush_events, 1, 1'b1);
        check("timeout_sticky", miss_timeout, 1, 1'b1);
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        check("rst_clears_timeout", miss_timeout, 0, 1'b1);
        next_cycle(); rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            next_cycle(); idle(); set_load_use();
        end
        next_cycle(); set_load_use(); cnt_clr = 1'b1;
        @(negedge clk);
        check("stall_saturates", stall_cycles, CMAX, 1'b1);
        next_cycle(); idle();
        @(negedge clk);
        check("clr_wins_over_inc", stall_cycles, 0, 1'b1);

        // Asynchronous reset in the middle of a MISS cycle.
        next_cycle(); dcache_miss = 1'b1;
        next_cycle(); dcache_miss = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_miss_outs", outs, 10'h01F, 1'b1);
        check("rst_mid_miss_stall", stall_cycles, 0, 1'b1);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("rst_mid_miss_run", outs, 10'h000, 1'b1);

        for (int n = 0; n < 800; n++) begin
            next_cycle();
            rst         = ($urandom_range(0, 199) == 0);
            rs1_ID      = 5'($urandom_range(0, 3));
            rs2_ID      = 5'($urandom_range(0, 3));
            rd_EX       = 5'($urandom_range(0, 3));
            rs1_used    = ($urandom_range(0, 1) == 1);
            rs2_used    = ($urandom_range(0, 1) == 1);
            load_EX     = ($urandom_range(0, 2) == 0);
            br_taken_EX = ($urandom_range(0, 5) == 0);
            jalr_EX     = ($urandom_range(0, 11) == 0);
            jal_ID      = ($urandom_range(0, 5) == 0);
            dcache_miss = ($urandom_range(0, 11) == 0);
            dcache_done = ($urandom_range(0, 3) == 0);
            cnt_clr     = ($urandom_range(0, 19) == 0);
        end
        next_cycle(); idle(); rst = 1'b0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
